// File: rtl/otter_mem_arbiter.sv
// Shares the single data-memory port between the MCU load/store path and the debug adapter.
// Optional build macro ARB_RR_EN selects round-robin arbitration (default: debug has fixed priority).
module otter_mem_arbiter #(
    parameter int unsigned READ_LAT = 1,
    parameter logic [31:0] MAX_ADDR = 32'h10FF_FFFF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mcu_req,
    input  logic        mcu_we,
    input  logic [31:0] mcu_addr,
    input  logic [1:0]  mcu_size,
    input  logic [31:0] mcu_wdata,
    output logic        mcu_ack,
    output logic        mcu_err,
    input  logic        dbg_req,
    input  logic        dbg_we,
    input  logic [31:0] dbg_addr,
    input  logic [1:0]  dbg_size,
    input  logic [31:0] dbg_wdata,
    output logic        dbg_ack,
    output logic        dbg_err,
    output logic [31:0] rdata,
    output logic        mem_rd,
    output logic        mem_wr,
    output logic [31:0] mem_addr,
    output logic [1:0]  mem_size,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_stall,
    output logic        busy,
    output logic        owner
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    localparam logic [3:0] LAT_INIT = 4'(READ_LAT);

    generate
        if (READ_LAT < 32'd1 || READ_LAT > 32'd15) begin : g_bad_read_lat
            $error("otter_mem_arbiter: READ_LAT must be within 1..15");
        end
    endgenerate

    state_t      state_q, state_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [1:0]  size_q, size_d;
    logic [31:0] wdata_q, wdata_d;
    logic        owner_q, owner_d;
    logic        err_q, err_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] rdata_q, rdata_d;
    logic        mcu_ack_q, mcu_ack_d;
    logic        dbg_ack_q, dbg_ack_d;
    logic        mcu_err_q, mcu_err_d;
    logic        dbg_err_q, dbg_err_d;
    logic        mem_rd_q, mem_rd_d;
    logic        mem_wr_q, mem_wr_d;
    logic        busy_q, busy_d;

    logic        grant_dbg_s;
    logic        sel_we_s;
    logic [31:0] sel_addr_s;
    logic [1:0]  sel_size_s;
    logic [31:0] sel_wdata_s;

`ifdef ARB_RR_EN
    logic        last_owner_q, last_owner_d;
`endif

    // Winner selection and the winner's command fields, consumed only in IDLE.
    always_comb begin
        grant_dbg_s = dbg_req;
`ifdef ARB_RR_EN
        // On a tie the requester that was not served last wins.
        if (mcu_req && dbg_req) begin
            grant_dbg_s = ~last_owner_q;
        end else begin
            grant_dbg_s = dbg_req;
        end
`endif
        if (grant_dbg_s) begin
            sel_we_s    = dbg_we;
            sel_addr_s  = dbg_addr;
            sel_size_s  = dbg_size;
            sel_wdata_s = dbg_wdata;
        end else begin
            sel_we_s    = mcu_we;
            sel_addr_s  = mcu_addr;
            sel_size_s  = mcu_size;
            sel_wdata_s = mcu_wdata;
        end
    end

    // Next-state and next-output logic; outputs are decoded from the next state so they leave flops.
    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        addr_d  = addr_q;
        size_d  = size_q;
        wdata_d = wdata_q;
        owner_d = owner_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
`ifdef ARB_RR_EN
        last_owner_d = last_owner_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (mcu_req || dbg_req) begin
                    owner_d = grant_dbg_s;
                    we_d    = sel_we_s;
                    addr_d  = sel_addr_s;
                    size_d  = sel_size_s;
                    wdata_d = sel_wdata_s;
                    if (sel_addr_s > MAX_ADDR) begin
                        err_d   = 1'b1;
                        rdata_d = 32'd0;
                        state_d = ST_RESP;
                    end else begin
                        err_d   = 1'b0;
                        state_d = ST_ISSUE;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (!mem_stall) begin
                    if (we_q) begin
                        state_d = ST_RESP;
                    end else begin
                        cnt_d   = LAT_INIT;
                        state_d = ST_WAIT;
                    end
                end else begin
                    state_d = ST_ISSUE;
                end
            end
            ST_WAIT: begin
                if (!mem_stall) begin
                    if (cnt_q == 4'd1) begin
                        rdata_d = mem_rdata;
                        state_d = ST_RESP;
                    end else begin
                        cnt_d   = cnt_q - 4'd1;
                        state_d = ST_WAIT;
                    end
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_RESP: begin
`ifdef ARB_RR_EN
                last_owner_d = owner_q;
`endif
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        mcu_ack_d = (state_d == ST_RESP) && !owner_d;
        dbg_ack_d = (state_d == ST_RESP) &&  owner_d;
        mcu_err_d = mcu_ack_d && err_d;
        dbg_err_d = dbg_ack_d && err_d;
        mem_rd_d  = (state_d == ST_ISSUE) && !we_d;
        mem_wr_d  = (state_d == ST_ISSUE) &&  we_d;
        busy_d    = (state_d != ST_IDLE);
    end

    // State, latched command and registered outputs; reset aborts any transaction in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            we_q      <= 1'b0;
            addr_q    <= 32'd0;
            size_q    <= 2'd0;
            wdata_q   <= 32'd0;
            owner_q   <= 1'b0;
            err_q     <= 1'b0;
            cnt_q     <= 4'd0;
            rdata_q   <= 32'd0;
            mcu_ack_q <= 1'b0;
            dbg_ack_q <= 1'b0;
            mcu_err_q <= 1'b0;
            dbg_err_q <= 1'b0;
            mem_rd_q  <= 1'b0;
            mem_wr_q  <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            size_q    <= size_d;
            wdata_q   <= wdata_d;
            owner_q   <= owner_d;
            err_q     <= err_d;
            cnt_q     <= cnt_d;
            rdata_q   <= rdata_d;
            mcu_ack_q <= mcu_ack_d;
            dbg_ack_q <= dbg_ack_d;
            mcu_err_q <= mcu_err_d;
            dbg_err_q <= dbg_err_d;
            mem_rd_q  <= mem_rd_d;
            mem_wr_q  <= mem_wr_d;
            busy_q    <= busy_d;
        end
    end

`ifdef ARB_RR_EN
    // Round-robin history: who was served by the most recent response.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_owner_q <= 1'b0;
        end else begin
            last_owner_q <= last_owner_d;
        end
    end
`endif

    assign mcu_ack   = mcu_ack_q;
    assign dbg_ack   = dbg_ack_q;
    assign mcu_err   = mcu_err_q;
    assign dbg_err   = dbg_err_q;
    assign rdata     = rdata_q;
    assign mem_rd    = mem_rd_q;
    assign mem_wr    = mem_wr_q;
    assign mem_addr  = addr_q;
    assign mem_size  = size_q;
    assign mem_wdata = wdata_q;
    assign busy      = busy_q;
    assign owner     = owner_q;

endmodule

// File: tb/tb_otter_mem_arbiter.sv
// Self-checking bench for otter_mem_arbiter: two instances (READ_LAT 1 and 3) share stimulus,
// expectations come from a transaction-level model counting unstalled edges per request.
module tb_otter_mem_arbiter;

    localparam logic [31:0] MAX_ADDR = 32'h10FF_FFFF;

    logic        clk = 1'b0;
    logic        reset;
    logic        mcu_req, mcu_we, dbg_req, dbg_we, mem_stall;
    logic [31:0] mcu_addr, mcu_wdata, dbg_addr, dbg_wdata, mem_rdata;
    logic [1:0]  mcu_size, dbg_size;

    logic        a_mcu_ack, a_mcu_err, a_dbg_ack, a_dbg_err, a_mem_rd, a_mem_wr, a_busy, a_owner;
    logic [31:0] a_rdata, a_mem_addr, a_mem_wdata;
    logic [1:0]  a_mem_size;
    logic        b_mcu_ack, b_mcu_err, b_dbg_ack, b_dbg_err, b_mem_rd, b_mem_wr, b_busy, b_owner;
    logic [31:0] b_rdata, b_mem_addr, b_mem_wdata;
    logic [1:0]  b_mem_size;

    int          n_cmp = 0;
    int          n_bad = 0;
    bit          m_last;
    logic [31:0] m_rd1, m_rd3;

    always #5 clk = ~clk;

    otter_mem_arbiter #(.READ_LAT(1), .MAX_ADDR(MAX_ADDR)) u_lat1 (
        .clk(clk), .reset(reset),
        .mcu_req(mcu_req), .mcu_we(mcu_we), .mcu_addr(mcu_addr), .mcu_size(mcu_size),
        .mcu_wdata(mcu_wdata), .mcu_ack(a_mcu_ack), .mcu_err(a_mcu_err),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_size(dbg_size),
        .dbg_wdata(dbg_wdata), .dbg_ack(a_dbg_ack), .dbg_err(a_dbg_err),
        .rdata(a_rdata), .mem_rd(a_mem_rd), .mem_wr(a_mem_wr), .mem_addr(a_mem_addr),
        .mem_size(a_mem_size), .mem_wdata(a_mem_wdata), .mem_rdata(mem_rdata),
        .mem_stall(mem_stall), .busy(a_busy), .owner(a_owner)
    );

    otter_mem_arbiter #(.READ_LAT(3), .MAX_ADDR(MAX_ADDR)) u_lat3 (
        .clk(clk), .reset(reset),
        .mcu_req(mcu_req), .mcu_we(mcu_we), .mcu_addr(mcu_addr), .mcu_size(mcu_size),
        .mcu_wdata(mcu_wdata), .mcu_ack(b_mcu_ack), .mcu_err(b_mcu_err),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_size(dbg_size),
        .dbg_wdata(dbg_wdata), .dbg_ack(b_dbg_ack), .dbg_err(b_dbg_err),
        .rdata(b_rdata), .mem_rd(b_mem_rd), .mem_wr(b_mem_wr), .mem_addr(b_mem_addr),
        .mem_size(b_mem_size), .mem_wdata(b_mem_wdata), .mem_rdata(mem_rdata),
        .mem_stall(mem_stall), .busy(b_busy), .owner(b_owner)
    );

    task automatic do_reset();
        reset = 1'b1; mcu_req = 1'b0; dbg_req = 1'b0; mem_stall = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        m_last = 1'b0; m_rd1 = 32'd0; m_rd3 = 32'd0;
    endtask

    function automatic logic [63:0] rand_mask();
        logic [63:0] m;
        m = 64'd0;
        for (int k = 1; k < 24; k++) m[k] = ($urandom_range(0, 99) < 30);
        return m;
    endfunction

    // One request sampled at the next edge; requests drop and fields are scrambled right after.
    task automatic run_txn(input logic [63:0] st_mask, input bit const_rd, input logic [31:0] rd_val);
        bit          win, t_we, t_err;
        logic [31:0] t_addr, t_wd, r1, r3;
        logic [1:0]  t_sz, ea, eb;
        logic [31:0] rdv [64];
        int          c1, c3, e1, n, last;
`ifdef ARB_RR_EN
        win = (mcu_req && dbg_req) ? !m_last : dbg_req;
`else
        win = dbg_req;
`endif
        t_we   = win ? dbg_we    : mcu_we;
        t_addr = win ? dbg_addr  : mcu_addr;
        t_sz   = win ? dbg_size  : mcu_size;
        t_wd   = win ? dbg_wdata : mcu_wdata;
        t_err  = (t_addr > MAX_ADDR);
        for (int k = 0; k < 64; k++) rdv[k] = const_rd ? rd_val : $urandom;
        c1 = 0; c3 = 0; e1 = 0; n = 0; r1 = m_rd1; r3 = m_rd3;
        if (t_err) begin
            c1 = 1; c3 = 1; r1 = 32'd0; r3 = 32'd0;
        end else begin
            for (int k = 1; k < 63; k++) begin
                if (!st_mask[k]) begin
                    if (e1 == 0) e1 = k;
                    n++;
                    if (c1 == 0 && n == (t_we ? 1 : 2)) begin c1 = k + 1; r1 = rdv[k]; end
                    if (c3 == 0 && n == (t_we ? 1 : 4)) begin c3 = k + 1; r3 = rdv[k]; end
                end
            end
        end
        @(posedge clk); #1;
        mcu_req = 1'b0; dbg_req = 1'b0;
        mcu_addr = $urandom; dbg_addr = $urandom; mcu_wdata = $urandom; dbg_wdata = $urandom;
        mcu_we = 1'($urandom); dbg_we = 1'($urandom);
        last = ((c1 > c3) ? c1 : c3) + 1;
        for (int k = 1; k <= last; k++) begin
            mem_stall = st_mask[k]; mem_rdata = rdv[k];
            ea = (k == c1) ? (win ? 2'b01 : 2'b10) : 2'b00;
            eb = (k == c3) ? (win ? 2'b01 : 2'b10) : 2'b00;
            n_cmp++;
            if ({a_mcu_ack, a_dbg_ack} !== ea) begin
                n_bad++; $display("FAIL ack_lat1 cyc=%0d got %b want %b", k, {a_mcu_ack, a_dbg_ack}, ea);
            end
            n_cmp++;
            if ({b_mcu_ack, b_dbg_ack} !== eb) begin
                n_bad++; $display("FAIL ack_lat3 cyc=%0d got %b want %b", k, {b_mcu_ack, b_dbg_ack}, eb);
            end
            n_cmp++;
            if ({a_mcu_err, a_dbg_err} !== (t_err ? ea : 2'b00)) begin
                n_bad++; $display("FAIL err_lat1 cyc=%0d got %b want %b", k, {a_mcu_err, a_dbg_err}, t_err ? ea : 2'b00);
            end
            if (k == c1 && (!t_we || t_err)) begin
                n_cmp++;
                if (a_rdata !== r1) begin
                    n_bad++; $display("FAIL rdata_lat1 cyc=%0d got %h want %h", k, a_rdata, r1);
                end
            end
            if (k == c3 && (!t_we || t_err)) begin
                n_cmp++;
                if (b_rdata !== r3) begin
                    n_bad++; $display("FAIL rdata_lat3 cyc=%0d got %h want %h", k, b_rdata, r3);
                end
            end
            n_cmp++;
            if ({a_mem_rd, a_mem_wr} !== {!t_err && !t_we && k <= e1, !t_err && t_we && k <= e1}) begin
                n_bad++; $display("FAIL strobe cyc=%0d got %b want %b", k, {a_mem_rd, a_mem_wr},
                                  {!t_err && !t_we && k <= e1, !t_err && t_we && k <= e1});
            end
            n_cmp++;
            if (a_busy !== (k <= c1)) begin
                n_bad++; $display("FAIL busy cyc=%0d got %b want %b", k, a_busy, k <= c1);
            end
            if (k <= c1) begin
                n_cmp++;
                if ({a_owner, a_mem_addr, a_mem_size, a_mem_wdata} !== {win, t_addr, t_sz, t_wd}) begin
                    n_bad++; $display("FAIL latch cyc=%0d got %b/%h/%0d/%h want %b/%h/%0d/%h", k,
                                      a_owner, a_mem_addr, a_mem_size, a_mem_wdata, win, t_addr, t_sz, t_wd);
                end
            end
            @(posedge clk); #1;
        end
        mem_stall = 1'b0;
        m_last = win;
        if (!t_we || t_err) begin m_rd1 = r1; m_rd3 = r3; end
    endtask

    task automatic test_reset();
        reset = 1'b1; mcu_req = 1'b1; dbg_req = 1'b1; mem_stall = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if ({a_mcu_ack, a_mcu_err, a_dbg_ack, a_dbg_err, a_mem_rd, a_mem_wr, a_busy, a_owner} !== 8'd0) begin
            n_bad++; $display("FAIL reset_flags_lat1 got %b want 0",
                              {a_mcu_ack, a_mcu_err, a_dbg_ack, a_dbg_err, a_mem_rd, a_mem_wr, a_busy, a_owner});
        end
        n_cmp++;
        if ({a_rdata, a_mem_addr, a_mem_size, a_mem_wdata} !== 98'd0) begin
            n_bad++; $display("FAIL reset_data_lat1 got %h/%h/%0d/%h want 0", a_rdata, a_mem_addr, a_mem_size, a_mem_wdata);
        end
        n_cmp++;
        if ({b_mcu_ack, b_dbg_ack, b_busy, b_mem_rd, b_mem_wr, b_rdata} !== 37'd0) begin
            n_bad++; $display("FAIL reset_lat3 got busy=%b rdata=%h want 0", b_busy, b_rdata);
        end
        do_reset();
    endtask

    task automatic test_basic_read();
        mcu_req = 1'b1; mcu_we = 1'b0; mcu_addr = 32'h100; mcu_size = 2'd2; mcu_wdata = 32'd0;
        run_txn(64'd0, 1'b1, 32'hDEAD_BEEF);
    endtask

    task automatic test_stalled_write();
        dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 32'h200; dbg_size = 2'd0; dbg_wdata = 32'h55;
        run_txn(64'b1110, 1'b0, 32'd0);
    endtask

    task automatic test_reject();
        dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 32'h1100_0000; dbg_size = 2'd2;
        run_txn(64'd0, 1'b0, 32'd0);
        dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = MAX_ADDR; dbg_size = 2'd0;
        run_txn(rand_mask(), 1'b0, 32'd0);
    endtask

    task automatic test_lat3_stall();
        mcu_req = 1'b1; mcu_we = 1'b0; mcu_addr = 32'h0000_0040; mcu_size = 2'd2;
        run_txn(64'b1000, 1'b0, 32'd0);
    endtask

    // Both requesters raise and hold; each holds until acked, winner re-requests at once.
    task automatic test_back_to_back();
        bit first, second;
        do_reset();
`ifdef ARB_RR_EN
        first = !m_last; second = !first;
`else
        first = 1'b1; second = 1'b1;
`endif
        mcu_req = 1'b1; mcu_we = 1'b1; mcu_addr = 32'h400; mcu_size = 2'd2; mcu_wdata = 32'h1111_1111;
        dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 32'h500; dbg_size = 2'd1; dbg_wdata = 32'h2222_2222;
        @(posedge clk); #1;
        for (int k = 1; k <= 7; k++) begin
            if (k == 1 || k == 4) begin
                n_cmp++;
                if (a_mem_addr !== ((k == 1 ? first : second) ? 32'h500 : 32'h400)) begin
                    n_bad++; $display("FAIL b2b_addr cyc=%0d got %h", k, a_mem_addr);
                end
            end
            n_cmp++;
            if ({a_mcu_ack, a_dbg_ack} !== ((k == 2) ? (first ? 2'b01 : 2'b10) :
                                            (k == 5) ? (second ? 2'b01 : 2'b10) : 2'b00)) begin
                n_bad++; $display("FAIL b2b_ack cyc=%0d got %b", k, {a_mcu_ack, a_dbg_ack});
            end
            n_cmp++;
            if (a_busy !== (k != 3 && k < 6)) begin
                n_bad++; $display("FAIL b2b_busy cyc=%0d got %b want %b", k, a_busy, k != 3 && k < 6);
            end
            if (k == 5) begin mcu_req = 1'b0; dbg_req = 1'b0; end
            @(posedge clk); #1;
        end
        m_last = second;
    endtask

    task automatic test_reset_mid();
        mcu_req = 1'b1; mcu_we = 1'b0; mcu_addr = 32'h300; mcu_size = 2'd2;
        @(posedge clk); #1;
        mcu_req = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        m_last = 1'b0; m_rd1 = 32'd0; m_rd3 = 32'd0;
        n_cmp++;
        if ({a_busy, b_busy, a_mem_rd, b_mem_rd} !== 4'd0) begin
            n_bad++; $display("FAIL abort_busy got %b want 0000", {a_busy, b_busy, a_mem_rd, b_mem_rd});
        end
        for (int k = 0; k < 5; k++) begin
            n_cmp++;
            if ({a_mcu_ack, a_dbg_ack, b_mcu_ack, b_dbg_ack} !== 4'd0) begin
                n_bad++; $display("FAIL abort_ack cyc=%0d got %b want 0000", k, {a_mcu_ack, a_dbg_ack, b_mcu_ack, b_dbg_ack});
            end
            @(posedge clk); #1;
        end
        mcu_req = 1'b1; mcu_we = 1'b0; mcu_addr = 32'h304; mcu_size = 2'd2;
        run_txn(64'd0, 1'b0, 32'd0);
    endtask

    task automatic test_random();
        int mode, sel;
        for (int i = 0; i < 40; i++) begin
            mode = $urandom_range(0, 2);
            mcu_we = 1'($urandom); dbg_we = 1'($urandom);
            mcu_size = 2'($urandom_range(0, 2)); dbg_size = 2'($urandom_range(0, 2));
            mcu_wdata = $urandom; dbg_wdata = $urandom;
            sel = $urandom_range(0, 9);
            mcu_addr = (sel == 0) ? MAX_ADDR : (sel == 1) ? MAX_ADDR + 32'd1 :
                       (sel == 2) ? 32'h1100_0000 + ($urandom % 32'h1000) : ($urandom & 32'h00FF_FFFC);
            sel = $urandom_range(0, 9);
            dbg_addr = (sel == 0) ? MAX_ADDR : (sel == 1) ? 32'hFFFF_FFFF : ($urandom & 32'h10FF_FFFF);
            mcu_req = (mode != 1);
            dbg_req = (mode != 0);
            run_txn(rand_mask(), 1'b0, 32'd0);
        end
    endtask

    initial begin
        mcu_we = 1'b0; mcu_addr = 32'd0; mcu_size = 2'd0; mcu_wdata = 32'd0;
        dbg_we = 1'b0; dbg_addr = 32'd0; dbg_size = 2'd0; dbg_wdata = 32'd0;
        mem_rdata = 32'd0;
        test_reset();
        test_basic_read();
        test_stalled_write();
        test_back_to_back();
        test_reject();
        test_reset_mid();
        test_lat3_stall();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
